// File: rtl/serdes_pkg.sv
// Shared constants and types for the 8:1 serial link (TX pattern generators and RX aligner).
package serdes_pkg;

    localparam int unsigned SERDES_WORD_W = 8;
    localparam logic [SERDES_WORD_W-1:0] SERDES_TRAIN_WORD = 8'h5C;

    typedef enum logic [1:0] {
        SETTLE = 2'd0,
        CHECK  = 2'd1,
        SLIP   = 2'd2,
        LOCKED = 2'd3
    } rx_align_state_t;

endpackage

// File: rtl/serdes_1to8_rx_align.sv
// Receive word aligner: bitslips the 1:8 deserializer until the training word lands
// aligned, then flags lock and qualifies the registered data stream.
//
// state  | meaning
// SETTLE | waiting SETTLE_CYCLES for deserializer output to settle; data ignored
// CHECK  | counting consecutive training words; any other word triggers a slip
// SLIP   | one-cycle bitslip pulse, slip counter advances
// LOCKED | aligned; payload passed through with o_valid
module serdes_1to8_rx_align
    import serdes_pkg::*;
#(
    parameter logic [SERDES_WORD_W-1:0] TRAIN         = SERDES_TRAIN_WORD,
    parameter int unsigned              MATCH_COUNT   = 16,
    parameter int unsigned              SETTLE_CYCLES = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [SERDES_WORD_W-1:0] i_data,
    input  logic                     i_realign,
    output logic                     o_bitslip,
    output logic                     o_locked,
    output logic [SERDES_WORD_W-1:0] o_data,
    output logic                     o_valid,
    output logic [2:0]               o_slip_count,
    output logic                     o_fail
);

    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES);
    localparam logic [7:0] MATCH_LAST  = 8'(MATCH_COUNT - 1);

    rx_align_state_t           state_q, state_d;
    logic [7:0]                settle_cnt_q, settle_cnt_d;
    logic [7:0]                match_cnt_q, match_cnt_d;
    logic [2:0]                slip_cnt_q, slip_cnt_d;
    logic                      fail_q, fail_d;
    logic                      locked_q, valid_q;
    logic [SERDES_WORD_W-1:0]  data_q;

    always_comb begin
        state_d      = state_q;
        settle_cnt_d = settle_cnt_q;
        match_cnt_d  = match_cnt_q;
        slip_cnt_d   = slip_cnt_q;
        fail_d       = fail_q;
        case (state_q)
            SETTLE: begin
                if (settle_cnt_q <= 8'd1) begin
                    state_d     = CHECK;
                    match_cnt_d = '0;
                end else begin
                    settle_cnt_d = settle_cnt_q - 8'd1;
                end
            end
            CHECK: begin
                if (i_data == TRAIN) begin
                    match_cnt_d = match_cnt_q + 8'd1;
                    if (match_cnt_q == MATCH_LAST) begin
                        state_d = LOCKED;
                    end
                end else begin
                    match_cnt_d = '0;
                    state_d     = SLIP;
                end
            end
            SLIP: begin
                slip_cnt_d   = slip_cnt_q + 3'd1;
                // a full rotation without lock: the link is dead or miswired
                if (slip_cnt_q == 3'd7) begin
                    fail_d = 1'b1;
                end
                state_d      = SETTLE;
                settle_cnt_d = SETTLE_LOAD;
            end
            default: ;
        endcase
        // realign overrides everything, including a fail set from a coincident slip
        if (i_realign) begin
            state_d      = SETTLE;
            settle_cnt_d = SETTLE_LOAD;
            match_cnt_d  = '0;
            fail_d       = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= SETTLE;
            settle_cnt_q <= SETTLE_LOAD;
            match_cnt_q  <= '0;
            slip_cnt_q   <= '0;
            fail_q       <= 1'b0;
            locked_q     <= 1'b0;
            valid_q      <= 1'b0;
            data_q       <= '0;
        end else begin
            state_q      <= state_d;
            settle_cnt_q <= settle_cnt_d;
            match_cnt_q  <= match_cnt_d;
            slip_cnt_q   <= slip_cnt_d;
            fail_q       <= fail_d;
            locked_q     <= (state_q == LOCKED) && !i_realign;
            valid_q      <= (state_q == LOCKED) && !i_realign;
            data_q       <= i_data;
        end
    end

    assign o_bitslip    = (state_q == SLIP);
    assign o_locked     = locked_q;
    assign o_valid      = valid_q;
    assign o_data       = data_q;
    assign o_slip_count = slip_cnt_q;
    assign o_fail       = fail_q;

endmodule

// File: tb/tb_serdes_1to8_rx_align.sv
// Directed + randomized bench for serdes_1to8_rx_align; expectations come from
// closed-form pulse/lock timing and a rotating-word deserializer model.
module tb_serdes_1to8_rx_align;
    import serdes_pkg::*;

    localparam int SETTLE = 4;
    localparam int MATCH  = 16;
    localparam int P      = SETTLE + 2;
    localparam int NEVER  = 1 << 30;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] i_data = 8'h00;
    logic       i_realign = 1'b0;
    logic       o_bitslip, o_locked, o_valid, o_fail;
    logic [7:0] o_data;
    logic [2:0] o_slip_count;

    serdes_1to8_rx_align #(
        .TRAIN(SERDES_TRAIN_WORD), .MATCH_COUNT(MATCH), .SETTLE_CYCLES(SETTLE)
    ) dut (
        .clk(clk), .reset_n(reset_n), .i_data(i_data), .i_realign(i_realign),
        .o_bitslip(o_bitslip), .o_locked(o_locked), .o_data(o_data),
        .o_valid(o_valid), .o_slip_count(o_slip_count), .o_fail(o_fail)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // expected timeline of the current scenario
    int p0, npulse, lock_at, base_cnt;
    bit fail_base;

    // link source: deserializer model (rotated training stream) or a raw word
    bit         use_ser;
    int         ser_off;
    logic [7:0] raw_word, last_drv;
    int         slip_apply[$];

    function automatic logic [7:0] deser_word(input int off);
        logic [7:0] t;
        logic [7:0] w;
        t = SERDES_TRAIN_WORD;
        for (int j = 0; j < 8; j++) w[j] = t[(j + off) % 8];
        return w;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h cyc=%0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic drive();
        i_data   = use_ser ? deser_word(ser_off) : raw_word;
        last_drv = i_data;
    endtask

    // t0: edge after which the aligner restarted; delay: extra clean CHECK cycles before the first slip
    task automatic scen(input int t0, input int delay, input int np, input int base, input bit fb);
        p0        = t0 + SETTLE + 1 + delay;
        npulse    = np;
        base_cnt  = base;
        fail_base = fb;
        lock_at   = (np == 0) ? t0 + SETTLE + MATCH + 1
                              : p0 + (np - 1) * P + SETTLE + MATCH + 2;
    endtask

    function automatic int n_done();
        int n;
        if (cyc <= p0) return 0;
        n = (cyc - p0 - 1) / P + 1;
        return (n < npulse) ? n : npulse;
    endfunction

    task automatic tick();
        int n;
        bit exp_pulse;
        @(posedge clk);
        #1;
        cyc++;
        n = n_done();
        exp_pulse = (cyc >= p0) && ((cyc - p0) % P == 0) && ((cyc - p0) / P < npulse);
        chk("bitslip", 32'(o_bitslip), 32'(exp_pulse));
        chk("locked", 32'(o_locked), 32'(cyc >= lock_at));
        chk("valid", 32'(o_valid), 32'(cyc >= lock_at));
        chk("data", 32'(o_data), 32'(last_drv));
        chk("slip_count", 32'(o_slip_count), 32'((base_cnt + n) % 8));
        chk("fail", 32'(o_fail), 32'(fail_base || (base_cnt + n >= 8)));
        // deserializer applies a bitslip two cycles after seeing the pulse
        if (o_bitslip) slip_apply.push_back(cyc + 2);
        while (slip_apply.size() > 0 && slip_apply[0] <= cyc) begin
            void'(slip_apply.pop_front());
            ser_off = (ser_off + 1) % 8;
        end
        drive();
    endtask

    task automatic do_reset(input bit ser, input int off, input logic [7:0] raw);
        use_ser  = ser;
        ser_off  = off;
        raw_word = raw;
        slip_apply.delete();
        i_realign = 1'b0;
        @(negedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        chk("rst_bitslip", 32'(o_bitslip), 32'd0);
        chk("rst_locked", 32'(o_locked), 32'd0);
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_data", 32'(o_data), 32'd0);
        chk("rst_slip_count", 32'(o_slip_count), 32'd0);
        chk("rst_fail", 32'(o_fail), 32'd0);
        drive();
        @(negedge clk);
        reset_n = 1'b1;
        cyc = 0;
    endtask

    initial begin
        int k, g;

        // aligned link
        do_reset(1'b1, 0, 8'h00);
        scen(0, 0, 0, 0, 1'b0);
        repeat (30) tick();

        // misaligned link needing 3 slips
        do_reset(1'b1, 5, 8'h00);
        scen(0, 0, 3, 0, 1'b0);
        repeat (3 * P + 30) tick();

        // misaligned by a random amount
        k = $urandom_range(1, 7);
        do_reset(1'b1, (8 - k) % 8, 8'h00);
        scen(0, 0, k, 0, 1'b0);
        repeat (k * P + 30) tick();

        // dead link: fail after the 8th slip, then pattern appears and links locks
        do_reset(1'b0, 0, 8'h00);
        scen(0, 0, 9, 0, 1'b0);
        while (cyc < SETTLE + 1 + 8 * P) tick();
        raw_word = SERDES_TRAIN_WORD;
        while (cyc < SETTLE + 1 + 8 * P + SETTLE + MATCH + 12) tick();

        // realign while locked with fail set
        scen(cyc + 1, 0, 0, 1, 1'b0);
        i_realign = 1'b1;
        tick();
        i_realign = 1'b0;
        repeat (30) tick();

        // glitch after 10 matches, then after a random number of matches
        for (int t = 0; t < 2; t++) begin
            g = (t == 0) ? 10 : int'($urandom_range(1, MATCH - 1));
            do_reset(1'b0, 0, SERDES_TRAIN_WORD);
            scen(0, g, 1, 0, 1'b0);
            while (cyc < SETTLE + g - 1) tick();
            raw_word = 8'hFF;
            tick();
            raw_word = SERDES_TRAIN_WORD;
            while (cyc < lock_at + 8) tick();
        end

        // async reset in the middle of CHECK, then full lock sequence again
        do_reset(1'b1, 0, 8'h00);
        scen(0, 0, 0, 0, 1'b0);
        repeat (12) tick();
        do_reset(1'b1, 0, 8'h00);
        scen(0, 0, 0, 0, 1'b0);
        repeat (30) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
